// File: rtl/mem_join_pkg.sv
// Shared types and helpers for the memory request join unit.
// Contents:
//   state_t  - join FSM state encoding (IDLE, WAIT, ACK)
//   cnt_w()  - width of the WAIT timeout counter for a given cycle limit
package mem_join_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int unsigned TIMEOUT_CYC_DEF = 1024;

   // Counter width for a timeout of cyc WAIT cycles; it counts 0 .. cyc-1.
   function automatic int unsigned cnt_w(input int unsigned cyc);
      return (cyc < 2) ? 1 : $clog2(cyc);
   endfunction

endpackage

// File: rtl/mem_join_chan.sv
// One channel of the memory request join unit: completion tracking, read data
// capture, bus strobe gating and CPU read data selection.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   state            join FSM state from the top level
//   all_done         every channel done this cycle (selects zero-wait in IDLE)
//   tmo              timeout hit: force a still-pending channel done with zero data
//   rd, wr           CPU request strobes for this channel
//   bus_ready        bus completion level for this channel
//   bus_rdata        bus read data for this channel
//   done             channel inactive, already done, or completing this cycle
//   bus_rd, bus_wr   gated bus strobes
//   cpu_rdata        read data to the CPU (pass-through in IDLE, captured otherwise)
module mem_join_chan
   import mem_join_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  state_t            state,
   input  logic              all_done,
   input  logic              tmo,
   input  logic              rd,
   input  logic              wr,
   input  logic              bus_ready,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              done,
   output logic              bus_rd,
   output logic              bus_wr,
   output logic [DATA_W-1:0] cpu_rdata
);

   logic              done_r;
   logic [DATA_W-1:0] cap_r;
   logic              active;
   logic              cap_en;

   assign active = rd | wr;
   assign done   = ~active | done_r | bus_ready;

   // Capture enable, strobe gating and read data selection.
   always_comb begin
      cap_en    = 1'b0;
      bus_rd    = 1'b0;
      bus_wr    = 1'b0;
      cpu_rdata = cap_r;
      case (state)
         IDLE: begin
            // In a zero-wait access nothing is latched; data passes straight through.
            cap_en    = active & bus_ready & ~all_done;
            bus_rd    = rd;
            bus_wr    = wr;
            cpu_rdata = bus_rdata;
         end
         WAIT: begin
            cap_en = active & bus_ready & ~done_r;
            bus_rd = rd & ~done_r;
            bus_wr = wr & ~done_r;
         end
         default: ;
      endcase
      if (rst) begin
         bus_rd    = 1'b0;
         bus_wr    = 1'b0;
         cpu_rdata = '0;
      end
   end

   // Completion flag and capture register; a real ready wins over a timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_r <= 1'b0;
         cap_r  <= '0;
      end else if (state != IDLE && state != WAIT) begin
         done_r <= 1'b0;
      end else if (cap_en) begin
         done_r <= 1'b1;
         cap_r  <= bus_rdata;
      end else if (state == WAIT && tmo && !done) begin
         done_r <= 1'b1;
         cap_r  <= '0;
      end
   end

endmodule

// File: rtl/mem_req_join.sv
// Stall/join unit between the CPU and the bus for NUM_CH parallel memory
// channels. Each channel is issued to the bus once per CPU access; the CPU is
// stalled until every requesting channel has completed.
// Optional feature macro: MEM_JOIN_TIMEOUT_EN (WAIT timeout with per-channel err_o).
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   mem_ready_o      CPU may advance (0 = stall)
//   cpu_rd_i/wr_i    per-channel requests, held while stalled
//   cpu_addr_i       per-channel address, passed to bus_addr_o
//   cpu_wdata_i      per-channel write data, passed to bus_wdata_o
//   cpu_rdata_o      per-channel read data to the CPU
//   bus_rd_o/wr_o    per-channel bus strobes
//   bus_rdata_i      per-channel bus read data
//   bus_ready_i      per-channel completion level
//   err_o            per-channel timeout flag (ACK cycle only)
module mem_req_join
   import mem_join_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   output logic                     mem_ready_o,
   input  logic [NUM_CH-1:0]        cpu_rd_i,
   input  logic [NUM_CH-1:0]        cpu_wr_i,
   input  logic [NUM_CH*ADDR_W-1:0] cpu_addr_i,
   input  logic [NUM_CH*DATA_W-1:0] cpu_wdata_i,
   output logic [NUM_CH*DATA_W-1:0] cpu_rdata_o,
   output logic [NUM_CH-1:0]        bus_rd_o,
   output logic [NUM_CH-1:0]        bus_wr_o,
   output logic [NUM_CH*ADDR_W-1:0] bus_addr_o,
   output logic [NUM_CH*DATA_W-1:0] bus_wdata_o,
   input  logic [NUM_CH*DATA_W-1:0] bus_rdata_i,
   input  logic [NUM_CH-1:0]        bus_ready_i,
   output logic [NUM_CH-1:0]        err_o
);

   // Elaboration-time parameter checks.
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("mem_req_join: NUM_CH must be 1..8");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("mem_req_join: TIMEOUT_CYC must be >= 2");
   end

   state_t            state_q;
   state_t            state_d;
   logic [NUM_CH-1:0] done_vec;
   logic              all_done;
   logic              tmo_hit;
   logic              mem_ready;

   assign all_done    = &done_vec;
   assign bus_addr_o  = cpu_addr_i;
   assign bus_wdata_o = cpu_wdata_i;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mem_join_chan #(
         .DATA_W (DATA_W)
      ) u_chan (
         .clk       (clk_i),
         .rst       (rst_i),
         .state     (state_q),
         .all_done  (all_done),
         .tmo       (tmo_hit),
         .rd        (cpu_rd_i[i]),
         .wr        (cpu_wr_i[i]),
         .bus_ready (bus_ready_i[i]),
         .bus_rdata (bus_rdata_i[i*DATA_W +: DATA_W]),
         .done      (done_vec[i]),
         .bus_rd    (bus_rd_o[i]),
         .bus_wr    (bus_wr_o[i]),
         .cpu_rdata (cpu_rdata_o[i*DATA_W +: DATA_W])
      );
   end

`ifdef MEM_JOIN_TIMEOUT_EN
   localparam int unsigned CNT_W = cnt_w(TIMEOUT_CYC);

   logic [CNT_W-1:0]  tmo_cnt;
   logic [NUM_CH-1:0] err_r;

   // Counter holds 0 outside WAIT, so it is clear on every WAIT entry.
   assign tmo_hit = (state_q == WAIT) && !all_done &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign err_o   = err_r;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt <= '0;
         err_r   <= '0;
      end else begin
         tmo_cnt <= (state_q == WAIT) ? tmo_cnt + CNT_W'(1) : '0;
         // Flags the channels forced done; visible for the following ACK cycle only.
         err_r   <= tmo_hit ? ~done_vec : '0;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign err_o   = '0;
`endif

   // Join FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Join FSM next state and stall output.
   always_comb begin
      state_d   = state_q;
      mem_ready = 1'b0;
      case (state_q)
         IDLE: begin
            mem_ready = all_done;
            if (!all_done) state_d = WAIT;
         end
         WAIT: begin
            if (all_done || tmo_hit) state_d = ACK;
         end
         ACK: begin
            mem_ready = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_ready_o = mem_ready & ~rst_i;

endmodule
